// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: synchronous 68000 bus target with two address windows
// (a fast DTACK window with programmable wait states, and a 6800-style
// VPA/VMA/E window) that both map onto one bank of eight 16-bit registers.
// Every output is registered; inputs are only consulted at the rising edge.
module m68k_bus_responder #(
  parameter logic [23:0] FAST_BASE   = 24'hE90000,
  parameter logic [23:0] SLOW_BASE   = 24'hBFE000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        M68K_CLK,
  input  logic        RST,
  input  logic [23:1] M68K_A,
  inout  wire  [15:0] M68K_D,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic        M68K_E,
  input  logic        M68K_VMA_n,
  output logic        M68K_DTACK_n,
  output logic        M68K_VPA_n,
  output logic        WR_STROBE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FWAIT = 3'd1;
  localparam logic [2:0] S_FACK  = 3'd2;
  localparam logic [2:0] S_VPEND = 3'd3;
  localparam logic [2:0] S_VACT  = 3'd4;
  localparam logic [2:0] S_VDONE = 3'd5;
  localparam logic [2:0] S_MISS  = 3'd6;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [2:0]  state_r;
  logic [3:0]  cnt_r;
  logic [2:0]  idx_r;
  logic        rd_r;
  logic        ds_seen_r;
  logic [15:0] dout_r;
  logic        drive_r;
  logic [15:0] regs_r [8];

  logic        fast_hit_s;
  logic        slow_hit_s;
  logic        ds_low_s;

  // Replace only the byte lanes whose data strobe is active (low).
  function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                              input logic [15:0] new_val,
                                              input logic        uds_n,
                                              input logic        lds_n);
    return {(uds_n ? old_val[15:8] : new_val[15:8]),
            (lds_n ? old_val[7:0]  : new_val[7:0])};
  endfunction

  // Window decode; the fast window wins when the two overlap.
  always_comb begin
    fast_hit_s = (M68K_A[23:4] == FAST_BASE[23:4]);
    if (fast_hit_s) begin
      slow_hit_s = 1'b0;
    end else begin
      slow_hit_s = (M68K_A[23:12] == SLOW_BASE[23:12]);
    end
    ds_low_s = ~M68K_UDS_n | ~M68K_LDS_n;
  end

  // The data bus is driven only from registered enable and data.
  assign M68K_D = drive_r ? dout_r : 16'hzzzz;

  // Bus cycle sequencer and register bank; RST abandons any cycle in flight.
  always_ff @(posedge M68K_CLK) begin
    if (RST) begin
      state_r      <= S_IDLE;
      cnt_r        <= 4'd0;
      idx_r        <= 3'd0;
      rd_r         <= 1'b1;
      ds_seen_r    <= 1'b0;
      dout_r       <= 16'h0000;
      drive_r      <= 1'b0;
      M68K_DTACK_n <= 1'b1;
      M68K_VPA_n   <= 1'b1;
      WR_STROBE    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else begin
      WR_STROBE <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (!M68K_AS_n) begin
            idx_r     <= M68K_A[3:1];
            rd_r      <= M68K_RW;
            ds_seen_r <= ds_low_s;
            cnt_r     <= WS;
            if (fast_hit_s) begin
              state_r <= S_FWAIT;
            end else if (slow_hit_s) begin
              state_r    <= S_VPEND;
              M68K_VPA_n <= 1'b0;
            end else begin
              state_r <= S_MISS;
            end
          end
        end
        S_FWAIT: begin
          // An abort wins over a counter that expires on the same edge.
          if (M68K_AS_n) begin
            state_r <= S_IDLE;
          end else if (!rd_r && !ds_seen_r) begin
            // Writes hold the count until a data strobe shows up.
            ds_seen_r <= ds_low_s;
          end else if (cnt_r == 4'd0) begin
            state_r      <= S_FACK;
            M68K_DTACK_n <= 1'b0;
            if (rd_r) begin
              drive_r <= 1'b1;
              dout_r  <= regs_r[idx_r];
            end else begin
              regs_r[idx_r] <= merge_lanes(regs_r[idx_r], M68K_D, M68K_UDS_n, M68K_LDS_n);
              WR_STROBE     <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_FACK: begin
          if (M68K_AS_n) begin
            state_r      <= S_IDLE;
            M68K_DTACK_n <= 1'b1;
            drive_r      <= 1'b0;
          end
        end
        S_VPEND: begin
          if (M68K_AS_n) begin
            state_r    <= S_IDLE;
            M68K_VPA_n <= 1'b1;
          end else if (!M68K_VMA_n) begin
            state_r <= S_VACT;
            if (rd_r) begin
              drive_r <= 1'b1;
              dout_r  <= regs_r[idx_r];
            end
          end
        end
        S_VACT: begin
          if (M68K_AS_n) begin
            state_r    <= S_IDLE;
            M68K_VPA_n <= 1'b1;
            drive_r    <= 1'b0;
          end else if (M68K_E && (rd_r || ds_low_s)) begin
            state_r <= S_VDONE;
            if (!rd_r) begin
              regs_r[idx_r] <= merge_lanes(regs_r[idx_r], M68K_D, M68K_UDS_n, M68K_LDS_n);
              WR_STROBE     <= 1'b1;
            end
          end
        end
        S_VDONE: begin
          if (M68K_AS_n) begin
            state_r    <= S_IDLE;
            M68K_VPA_n <= 1'b1;
            drive_r    <= 1'b0;
          end
        end
        S_MISS: begin
          if (M68K_AS_n) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          M68K_DTACK_n <= 1'b1;
          M68K_VPA_n   <= 1'b1;
          drive_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder: drives randomized 68000 bus cycles into the
// responder and compares every clock against a transaction-level model that
// derives expected DTACK/VPA/strobe/data timing from edge offsets within each
// cycle and keeps its own copy of the register bank.
module tb_m68k_bus_responder;

  localparam int          WS        = 2;
  localparam logic [23:0] FAST_BASE = 24'hE90000;
  localparam logic [23:0] SLOW_BASE = 24'hBFE000;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:1] addr;
  tri1  [15:0] bus_d;
  logic        as_n, uds_n, lds_n, rw, e_clk, vma_n;
  logic        dtack_n, vpa_n, wr_strobe;
  logic        tb_drv;
  logic [15:0] tb_dat;

  // expected outputs after the next rising edge
  logic        exp_chk, exp_dtack, exp_vpa, exp_drive, exp_strobe;
  logic [15:0] exp_data;

  logic [15:0] model_regs [8];
  int          e_ph = 0;
  int          edge_no = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          dtack_fall_edge = 0;
  logic [15:0] drv_last = 16'h0000;

  assign bus_d = tb_drv ? tb_dat : 16'hzzzz;

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  m68k_bus_responder #(
    .FAST_BASE   (FAST_BASE),
    .SLOW_BASE   (SLOW_BASE),
    .WAIT_STATES (WS)
  ) dut (
    .M68K_CLK     (clk),
    .RST          (rst),
    .M68K_A       (addr),
    .M68K_D       (bus_d),
    .M68K_AS_n    (as_n),
    .M68K_UDS_n   (uds_n),
    .M68K_LDS_n   (lds_n),
    .M68K_RW      (rw),
    .M68K_E       (e_clk),
    .M68K_VMA_n   (vma_n),
    .M68K_DTACK_n (dtack_n),
    .M68K_VPA_n   (vpa_n),
    .WR_STROBE    (wr_strobe)
  );

  // Per-cycle comparison of DUT outputs against the model's expectations.
  initial begin : compare
    logic        c_chk, c_dt, c_vp, c_dr, c_st;
    logic [15:0] c_da, want_bus;
    logic        prev_dtack;
    prev_dtack = 1'b1;
    forever begin
      @(posedge clk);
      c_chk = exp_chk; c_dt = exp_dtack; c_vp = exp_vpa;
      c_dr  = exp_drive; c_st = exp_strobe; c_da = exp_data;
      @(negedge clk);
      if (prev_dtack === 1'b1 && dtack_n === 1'b0) dtack_fall_edge = edge_no;
      prev_dtack = dtack_n;
      if (c_dr) drv_last = bus_d;
      if (c_chk) begin
        want_bus = c_dr ? c_da : (tb_drv ? tb_dat : 16'hFFFF);
        n_checks++;
        if (dtack_n !== c_dt || vpa_n !== c_vp || wr_strobe !== c_st || bus_d !== want_bus) begin
          $display("FAIL bus_cycle edge=%0d dtack=%b want %b vpa=%b want %b strobe=%b want %b d=%h want %h",
                   edge_no, dtack_n, c_dt, vpa_n, c_vp, wr_strobe, c_st, bus_d, want_bus);
        end else begin
          n_pass++;
        end
      end
    end
  end

  function automatic logic [15:0] lane_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                             input bit up, input bit lo);
    return {(up ? new_v[15:8] : old_v[15:8]), (lo ? new_v[7:0] : old_v[7:0])};
  endfunction

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s got=%h want=%h", name, got, want);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // E clock: 6 clocks low, 4 clocks high
  task automatic adv_e();
    e_ph  = (e_ph + 1) % 10;
    e_clk = (e_ph >= 6);
  endtask

  task automatic idle_exp();
    exp_dtack = 1'b1; exp_vpa = 1'b1; exp_drive = 1'b0; exp_strobe = 1'b0; exp_data = 16'h0000;
  endtask

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) begin
      adv_e();
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; vma_n = 1'b1; rw = 1'b1; tb_drv = 1'b0;
      idle_exp();
      tick();
    end
  endtask

  // Fast-window cycle. DTACK falls ack_t edges after AS for reads, or
  // 1+WS edges after the data strobe is first sampled for writes.
  task automatic fast_cycle(input bit rd, input logic [2:0] idx, input logic [15:0] wdat,
                            input bit up, input bit lo, input int d, input int hold,
                            input int abort_at, output int ds_edge);
    int start_t, ack_t, end_t;
    start_t = rd ? 0 : d;
    ack_t   = start_t + 1 + WS;
    end_t   = (abort_at > 0 && abort_at <= ack_t) ? abort_at : ack_t + hold;
    ds_edge = -1;
    for (int t = 0; t < end_t; t++) begin
      adv_e();
      addr = {FAST_BASE[23:4], idx};
      as_n = 1'b0; rw = rd; vma_n = 1'b1;
      if (rd) begin
        uds_n = 1'b0; lds_n = 1'b0; tb_drv = 1'b0;
      end else begin
        tb_drv = 1'b1; tb_dat = wdat;
        uds_n = !(up && t >= d); lds_n = !(lo && t >= d);
      end
      if (t == start_t) ds_edge = edge_no + 1;
      exp_dtack  = !(t >= ack_t);
      exp_vpa    = 1'b1;
      exp_drive  = rd && (t >= ack_t);
      exp_data   = model_regs[idx];
      exp_strobe = !rd && (t == ack_t);
      tick();
      if (!rd && t == ack_t) model_regs[idx] = lane_merge(model_regs[idx], wdat, up, lo);
    end
    bus_idle(1 + $urandom_range(0, 2));
  endtask

  // VPA-window cycle: VPA low from the decode edge, read data from the
  // VMA edge, completion on the first E-high edge after VMA was taken.
  task automatic slow_cycle(input bit rd, input logic [2:0] idx, input logic [15:0] wdat,
                            input bit up, input bit lo, input int v, input int hold,
                            input int abort_at);
    logic [7:0] mid;
    int t_done;
    mid    = 8'($urandom);
    t_done = -1;
    for (int t = 0; t < 40; t++) begin
      if (abort_at > 0 && t >= abort_at) break;
      if (t_done >= 0 && t > t_done + hold) break;
      adv_e();
      addr  = {SLOW_BASE[23:12], mid, idx};
      as_n  = 1'b0; rw = rd; vma_n = !(t >= v);
      if (rd) begin
        uds_n = 1'b0; lds_n = 1'b0; tb_drv = 1'b0;
      end else begin
        uds_n = !up; lds_n = !lo; tb_drv = 1'b1; tb_dat = wdat;
      end
      exp_dtack  = 1'b1;
      exp_vpa    = 1'b0;
      exp_drive  = rd && (t >= v);
      exp_data   = model_regs[idx];
      exp_strobe = 1'b0;
      if (t_done < 0 && t > v && e_clk) begin
        t_done     = t;
        exp_strobe = !rd;
      end
      tick();
      if (exp_strobe) model_regs[idx] = lane_merge(model_regs[idx], wdat, up, lo);
    end
    bus_idle(1 + $urandom_range(0, 2));
  endtask

  task automatic miss_cycle(input int n);
    logic r;
    r = 1'($urandom);
    for (int t = 0; t < n; t++) begin
      adv_e();
      addr = {4'h0, 19'($urandom)};
      as_n = 1'b0; rw = r; uds_n = 1'b0; lds_n = 1'b0; vma_n = 1'b0;
      tb_drv = !r; tb_dat = 16'h5A5A;
      idle_exp();
      tick();
    end
    bus_idle(1 + $urandom_range(0, 2));
  endtask

  task automatic reset_in_fack(input logic [2:0] idx);
    for (int t = 0; t < WS + 3; t++) begin
      adv_e();
      addr = {FAST_BASE[23:4], idx};
      as_n = 1'b0; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; vma_n = 1'b1; tb_drv = 1'b0;
      exp_dtack = !(t >= WS + 1); exp_vpa = 1'b1; exp_drive = (t >= WS + 1);
      exp_data  = model_regs[idx]; exp_strobe = 1'b0;
      tick();
    end
    adv_e();
    rst = 1'b1;
    idle_exp();
    tick();
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    rst = 1'b0;
    bus_idle(2);
  endtask

  initial begin : main
    int ds_e, kind;
    logic [2:0]  idx;
    logic [15:0] dat;
    int lanes;

    rst = 1'b1; addr = '0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    e_clk = 1'b0; vma_n = 1'b1; tb_drv = 1'b0; tb_dat = 16'h0000;
    exp_chk = 1'b1;
    idle_exp();
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      adv_e();
      tick();
    end
    rst = 1'b0;
    bus_idle(2);

    // fast write then read-back of reg3 with latency pinned to 1+WS
    fast_cycle(1'b0, 3'd3, 16'hA55A, 1'b1, 1'b1, 1, 1, -1, ds_e);
    check_lit("fast_wr_latency", dtack_fall_edge - ds_e, 32'd3);
    check_lit("model_reg3", {16'h0000, model_regs[3]}, 32'h0000A55A);
    drv_last = 16'h0BAD;
    fast_cycle(1'b1, 3'd3, 16'h0000, 1'b1, 1'b1, 0, 2, -1, ds_e);
    check_lit("fast_rd_latency", dtack_fall_edge - ds_e, 32'd3);
    check_lit("fast_rd_data", {16'h0000, drv_last}, 32'h0000A55A);

    // byte lanes on reg0
    fast_cycle(1'b0, 3'd0, 16'h1234, 1'b1, 1'b1, 0, 1, -1, ds_e);
    fast_cycle(1'b0, 3'd0, 16'hFFA7, 1'b1, 1'b0, 2, 2, -1, ds_e);
    check_lit("model_uds_only", {16'h0000, model_regs[0]}, 32'h0000FF34);
    drv_last = 16'h0BAD;
    fast_cycle(1'b1, 3'd0, 16'h0000, 1'b1, 1'b1, 0, 1, -1, ds_e);
    check_lit("uds_only_rd", {16'h0000, drv_last}, 32'h0000FF34);
    fast_cycle(1'b0, 3'd0, 16'h5A00, 1'b0, 1'b1, 0, 1, -1, ds_e);
    drv_last = 16'h0BAD;
    fast_cycle(1'b1, 3'd0, 16'h0000, 1'b1, 1'b1, 0, 1, -1, ds_e);
    check_lit("lds_only_rd", {16'h0000, drv_last}, 32'h0000FF00);

    // VPA window: write BEEF to reg1, read it back
    slow_cycle(1'b0, 3'd1, 16'hBEEF, 1'b1, 1'b1, 1, 1, -1);
    check_lit("model_reg1", {16'h0000, model_regs[1]}, 32'h0000BEEF);
    drv_last = 16'h0BAD;
    slow_cycle(1'b1, 3'd1, 16'h0000, 1'b1, 1'b1, 2, 2, -1);
    check_lit("vpa_rd_data", {16'h0000, drv_last}, 32'h0000BEEF);

    // miss, then fast write aborted early and on the expiry edge
    miss_cycle(5);
    fast_cycle(1'b0, 3'd5, 16'h1111, 1'b1, 1'b1, 0, 1, 2, ds_e);
    fast_cycle(1'b0, 3'd5, 16'h2222, 1'b1, 1'b1, 1, 1, 1 + 1 + WS, ds_e);
    check_lit("abort_model_reg5", {16'h0000, model_regs[5]}, 32'h00000000);
    fast_cycle(1'b1, 3'd5, 16'h0000, 1'b1, 1'b1, 0, 1, -1, ds_e);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      kind  = $urandom_range(0, 6);
      idx   = 3'($urandom);
      dat   = 16'($urandom);
      lanes = $urandom_range(1, 3);
      case (kind)
        0: fast_cycle(1'b1, idx, dat, 1'b1, 1'b1, 0, $urandom_range(1, 3), -1, ds_e);
        1: fast_cycle(1'b0, idx, dat, lanes[1], lanes[0], $urandom_range(0, 3),
                      $urandom_range(1, 3), -1, ds_e);
        2: slow_cycle(1'b1, idx, dat, 1'b1, 1'b1, $urandom_range(1, 4), $urandom_range(0, 2), -1);
        3: slow_cycle(1'b0, idx, dat, lanes[1], lanes[0], $urandom_range(1, 4),
                      $urandom_range(0, 2), -1);
        4: miss_cycle($urandom_range(1, 4));
        5: fast_cycle(1'($urandom), idx, dat, lanes[1], lanes[0], $urandom_range(0, 2), 1,
                      $urandom_range(1, 3 + WS), ds_e);
        default: slow_cycle(1'($urandom), idx, dat, lanes[1], lanes[0], $urandom_range(1, 4), 1,
                            $urandom_range(1, 8));
      endcase
    end

    // reset while a read is in its acknowledge phase, then normal service
    fast_cycle(1'b0, 3'd6, 16'hC3C3, 1'b1, 1'b1, 0, 1, -1, ds_e);
    reset_in_fack(3'd6);
    for (int i = 0; i < 8; i++) begin
      fast_cycle(1'b1, 3'(i), 16'h0000, 1'b1, 1'b1, 0, 1, -1, ds_e);
    end
    fast_cycle(1'b0, 3'd2, 16'h7E81, 1'b1, 1'b1, 0, 1, -1, ds_e);
    drv_last = 16'h0BAD;
    fast_cycle(1'b1, 3'd2, 16'h0000, 1'b1, 1'b1, 0, 1, -1, ds_e);
    check_lit("post_reset_rd", {16'h0000, drv_last}, 32'h00007E81);

    bus_idle(2);
    exp_chk = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
